// File: rtl/fabric_stream_dma.sv
// fabric_stream_dma: read-side DMA sequencer that fetches depth words at base + i*stride*(DATA_WIDTH/8) and streams them in order to the fabric lanes.
//   s_axi_aclk / s_axi_aresetn : clock and synchronous active-low reset
//   fabric_base_addr/depth/stride/start : run request, latched on the IDLE start
//   fabric_done / fabric_busy          : one-cycle completion pulse, run-in-progress flag
//   m_rd_addr/valid/ready              : memory read request channel
//   m_rd_data/dvalid                   : in-order read return (no backpressure)
//   t_data/valid/last/ready            : output stream to the fabric lanes
module fabric_stream_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] fabric_base_addr,
    input  logic [15:0]           fabric_depth,
    input  logic [7:0]            fabric_stride,
    input  logic                  fabric_start,
    output logic                  fabric_done,
    output logic                  fabric_busy,
    output logic [ADDR_WIDTH-1:0] m_rd_addr,
    output logic                  m_rd_valid,
    input  logic                  m_rd_ready,
    input  logic [DATA_WIDTH-1:0] m_rd_data,
    input  logic                  m_rd_dvalid,
    output logic [DATA_WIDTH-1:0] t_data,
    output logic                  t_valid,
    output logic                  t_last,
    input  logic                  t_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FD = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           depth_q, depth_d;
    logic [7:0]            stride_q, stride_d;
    logic [15:0]           issued_q, issued_d;
    logic [15:0]           delivered_q, delivered_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         credit;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  active, accept, push, pop;

    always_comb begin
        active      = (state_q == RUN) || (state_q == DRAIN);
        // Every in-flight read owns a FIFO slot, so the buffer can never overflow.
        credit      = FD - count_q - outst_q;
        m_rd_valid  = (state_q == RUN) && (issued_q < depth_q) && (credit != '0);
        m_rd_addr   = addr_q;
        accept      = m_rd_valid && m_rd_ready;
        // Returns that land outside a run belong to an aborted run and are dropped.
        push        = active && m_rd_dvalid;
        t_valid     = count_q != '0;
        t_data      = t_valid ? mem_q[rd_ptr_q] : '0;
        t_last      = t_valid && (delivered_q == depth_q - 16'd1);
        pop         = t_valid && t_ready;
        fabric_done = state_q == DONE;
        fabric_busy = active;
        outst_d     = outst_q + CW'(accept) - CW'(push);
        count_d     = count_q + CW'(push) - CW'(pop);
        issued_d    = issued_q + 16'(accept);
        delivered_d = delivered_q + 16'(pop);
        addr_d      = accept ? addr_q + ADDR_WIDTH'(stride_q) * BYTES : addr_q;
        depth_d     = depth_q;
        stride_d    = stride_q;
        state_d     = state_q;
        case (state_q)
            IDLE: if (fabric_start) begin
                addr_d      = fabric_base_addr;
                depth_d     = fabric_depth;
                stride_d    = fabric_stride;
                issued_d    = '0;
                delivered_d = '0;
                state_d     = (fabric_depth == '0) ? DONE : RUN;
            end
            RUN:   state_d = (accept && issued_d == depth_q) ? DRAIN : RUN;
            DRAIN: state_d = (pop && delivered_d == depth_q) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            depth_q     <= '0;
            stride_q    <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            outst_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            depth_q     <= depth_d;
            stride_q    <= stride_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            outst_q     <= outst_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= m_rd_data;
    end

    a_no_overflow: assert property (@(posedge s_axi_aclk) disable iff (!s_axi_aresetn)
        !(push && count_q == FD));
endmodule
